// File: rtl/cpu_pkg.sv
// Shared pipeline types for the ID/EX -> EX/MEM boundary: control/data bundles,
// ALU opcode classes, ALU operations and forwarding-mux selects.
package cpu_pkg;

   localparam int CPU_XLEN = 32;

   typedef enum logic [1:0] {
      ALU_OP_LOADSTORE = 2'b00,
      ALU_OP_BRANCH    = 2'b01,
      ALU_OP_RTYPE     = 2'b10,
      ALU_OP_ITYPE     = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_ctrl_e;

   // Encoding 2'b11 is reserved and behaves like FWD_REG.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic    WB_reg_write;
      logic    WB_mem_to_reg;
      logic    M_branch;
      logic    M_mem_read;
      logic    M_mem_write;
      logic    EX_ALU_Src;
      alu_op_e EX_ALU_Op;
   } pipeline_control_t_if_id;

   typedef struct packed {
      logic [CPU_XLEN-1:0] pc_address;
      logic [CPU_XLEN-1:0] reg_read_data1;
      logic [CPU_XLEN-1:0] reg_read_data2;
      logic [CPU_XLEN-1:0] imm;
      logic [3:0]          funct_inst_bits;  // {funct7[5], funct3}
      logic [4:0]          rd;
   } pipeline_data_t_if_id;

   typedef struct packed {
      logic WB_reg_write;
      logic WB_mem_to_reg;
      logic M_branch;
      logic M_mem_read;
      logic M_mem_write;
   } ex_mem_control_t;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-control decode: opcode class plus {funct7[5], funct3}
// to an ALU operation, flagging combinations the ALU does not support.
module alu_control
   import cpu_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [3:0] funct_inst_bits,
   output alu_ctrl_e  alu_ctrl,
   output logic       illegal
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (alu_op)
         ALU_OP_LOADSTORE: alu_ctrl = ALU_ADD;
         ALU_OP_BRANCH:    alu_ctrl = ALU_SUB;
         ALU_OP_RTYPE: begin
            case (funct_inst_bits)
               4'b0000: alu_ctrl = ALU_ADD;
               4'b1000: alu_ctrl = ALU_SUB;
               4'b0111: alu_ctrl = ALU_AND;
               4'b0110: alu_ctrl = ALU_OR;
               default: illegal  = 1'b1;
            endcase
         end
         ALU_OP_ITYPE: begin
            // funct7[5] carries immediate bits for I-type, so only funct3 decodes.
            case (funct_inst_bits[2:0])
               3'b000:  alu_ctrl = ALU_ADD;
               3'b111:  alu_ctrl = ALU_AND;
               3'b110:  alu_ctrl = ALU_OR;
               default: illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_stage_reg.sv
// Execute stage: operand forwarding, ALU, branch target, and the EX/MEM
// pipeline register with flush-over-stall priority.
module ex_stage_reg
   import cpu_pkg::*;
#(
   parameter int              XLEN         = CPU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  pipeline_control_t_if_id id_ex_ctrl,
   input  pipeline_data_t_if_id    id_ex_data,
   input  logic                    id_ex_valid,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [1:0]              fwd_a_sel,
   input  logic [1:0]              fwd_b_sel,
   input  logic [XLEN-1:0]         mem_fwd_data,
   input  logic [XLEN-1:0]         wb_fwd_data,
   output ex_mem_control_t         ex_mem_ctrl_q,
   output logic [XLEN-1:0]         alu_result_q,
   output logic                    zero_q,
   output logic [XLEN-1:0]         store_data_q,
   output logic [XLEN-1:0]         branch_target_q,
   output logic [4:0]              rd_q,
   output logic                    valid_q,
   output logic                    illegal_q
);

   alu_ctrl_e       alu_ctrl;
   logic            funct_illegal;
   logic [XLEN-1:0] op_a, fwd_b, op_b;
   logic [XLEN-1:0] alu_result, branch_target;
   ex_mem_control_t ctrl_next;

   function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] wb_val,
                                                input logic [XLEN-1:0] mem_val);
      case (sel)
         FWD_WB:  return wb_val;
         FWD_MEM: return mem_val;
         default: return reg_val;
      endcase
   endfunction

   alu_control u_alu_control (
      .alu_op          (id_ex_ctrl.EX_ALU_Op),
      .funct_inst_bits (id_ex_data.funct_inst_bits),
      .alu_ctrl        (alu_ctrl),
      .illegal         (funct_illegal)
   );

   assign op_a  = fwd_pick(fwd_a_sel, id_ex_data.reg_read_data1, wb_fwd_data, mem_fwd_data);
   assign fwd_b = fwd_pick(fwd_b_sel, id_ex_data.reg_read_data2, wb_fwd_data, mem_fwd_data);
   assign op_b  = id_ex_ctrl.EX_ALU_Src ? id_ex_data.imm : fwd_b;

   always_comb begin
      alu_result = op_a + op_b;
      case (alu_ctrl)
         ALU_SUB: alu_result = op_a - op_b;
         ALU_AND: alu_result = op_a & op_b;
         ALU_OR:  alu_result = op_a | op_b;
         default: alu_result = op_a + op_b;
      endcase
   end

   assign branch_target = id_ex_data.pc_address + (id_ex_data.imm << 1);

   assign ctrl_next = '{
      WB_reg_write:  id_ex_ctrl.WB_reg_write,
      WB_mem_to_reg: id_ex_ctrl.WB_mem_to_reg,
      M_branch:      id_ex_ctrl.M_branch,
      M_mem_read:    id_ex_ctrl.M_mem_read,
      M_mem_write:   id_ex_ctrl.M_mem_write
   };

   // NOTE: state uses non-blocking assignments so all fields update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_mem_ctrl_q   <= '0;
         alu_result_q    <= '0;
         zero_q          <= 1'b0;
         store_data_q    <= '0;
         branch_target_q <= RESET_PC_OUT;
         rd_q            <= '0;
         valid_q         <= 1'b0;
         illegal_q       <= 1'b0;
      end else if (flush) begin
         ex_mem_ctrl_q   <= '0;
         alu_result_q    <= '0;
         zero_q          <= 1'b0;
         store_data_q    <= '0;
         branch_target_q <= '0;
         rd_q            <= '0;
         valid_q         <= 1'b0;
         illegal_q       <= 1'b0;
      end else if (!stall) begin
         // A bubble keeps its data but must carry no side-effecting control.
         ex_mem_ctrl_q   <= id_ex_valid ? ctrl_next : '0;
         alu_result_q    <= alu_result;
         zero_q          <= (alu_result == '0);
         store_data_q    <= fwd_b;
         branch_target_q <= branch_target;
         rd_q            <= id_ex_data.rd;
         valid_q         <= id_ex_valid;
         illegal_q       <= id_ex_valid & funct_illegal;
      end
   end

endmodule

// File: tb/tb_ex_stage_reg.sv
// Self-checking bench for ex_stage_reg: directed scenarios then random traffic,
// each cycle compared against a behavioural model of the EX/MEM register.
module tb_ex_stage_reg;
   import cpu_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic                    clk = 1'b0;
   logic                    rst;
   pipeline_control_t_if_id id_ex_ctrl;
   pipeline_data_t_if_id    id_ex_data;
   logic                    id_ex_valid, stall, flush;
   logic [1:0]              fwd_a_sel, fwd_b_sel;
   logic [31:0]             mem_fwd_data, wb_fwd_data;
   ex_mem_control_t         ex_mem_ctrl_q;
   logic [31:0]             alu_result_q, store_data_q, branch_target_q;
   logic                    zero_q, valid_q, illegal_q;
   logic [4:0]              rd_q;

   ex_stage_reg #(.XLEN(32), .RESET_PC_OUT(RESET_PC)) dut (
      .clk(clk), .rst(rst), .id_ex_ctrl(id_ex_ctrl), .id_ex_data(id_ex_data),
      .id_ex_valid(id_ex_valid), .stall(stall), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .ex_mem_ctrl_q(ex_mem_ctrl_q), .alu_result_q(alu_result_q), .zero_q(zero_q),
      .store_data_q(store_data_q), .branch_target_q(branch_target_q),
      .rd_q(rd_q), .valid_q(valid_q), .illegal_q(illegal_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ctrl;
      logic [31:0] alu;
      logic        zero;
      logic [31:0] store;
      logic [31:0] bt;
      logic [4:0]  rd;
      logic        valid;
      logic        illegal;
   } exp_t;

   exp_t m, saved;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t reset_state();
      exp_t r = '{default: 0};
      r.bt = RESET_PC;
      return r;
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
      if (sel == 2'd1) return wb_fwd_data;
      if (sel == 2'd2) return mem_fwd_data;
      return r;
   endfunction

   // Next EX/MEM contents from the current inputs, straight from the stage's rules.
   function automatic exp_t model_next(input exp_t cur);
      exp_t        n = '{default: 0};
      logic [31:0] a, b, r;
      logic [3:0]  f;
      logic        ill;
      if (flush) return n;
      if (stall) return cur;
      a       = pick(fwd_a_sel, id_ex_data.reg_read_data1);
      n.store = pick(fwd_b_sel, id_ex_data.reg_read_data2);
      b       = id_ex_ctrl.EX_ALU_Src ? id_ex_data.imm : n.store;
      f       = id_ex_data.funct_inst_bits;
      ill     = 1'b0;
      r       = a + b;
      case (2'(id_ex_ctrl.EX_ALU_Op))
         2'd0: r = a + b;
         2'd1: r = a - b;
         2'd2: begin
            if      (f == 4'h0) r = a + b;
            else if (f == 4'h8) r = a - b;
            else if (f == 4'h7) r = a & b;
            else if (f == 4'h6) r = a | b;
            else ill = 1'b1;
         end
         default: begin
            if      (f[2:0] == 3'd0) r = a + b;
            else if (f[2:0] == 3'd7) r = a & b;
            else if (f[2:0] == 3'd6) r = a | b;
            else ill = 1'b1;
         end
      endcase
      n.alu     = r;
      n.zero    = (r == 32'd0);
      n.bt      = id_ex_data.pc_address + id_ex_data.imm * 32'd2;
      n.rd      = id_ex_data.rd;
      n.valid   = id_ex_valid;
      n.illegal = ill && id_ex_valid;
      n.ctrl    = id_ex_valid ? {id_ex_ctrl.WB_reg_write, id_ex_ctrl.WB_mem_to_reg,
                                 id_ex_ctrl.M_branch, id_ex_ctrl.M_mem_read,
                                 id_ex_ctrl.M_mem_write} : 5'd0;
      return n;
   endfunction

   task automatic check_all(input string t);
      check({t, ".ctrl"},    ex_mem_ctrl_q,   m.ctrl);
      check({t, ".alu"},     alu_result_q,    m.alu);
      check({t, ".zero"},    zero_q,          m.zero);
      check({t, ".store"},   store_data_q,    m.store);
      check({t, ".target"},  branch_target_q, m.bt);
      check({t, ".rd"},      rd_q,            m.rd);
      check({t, ".valid"},   valid_q,         m.valid);
      check({t, ".illegal"}, illegal_q,       m.illegal);
   endtask

   task automatic tick(input string t);
      m = model_next(m);
      @(posedge clk);
      #1;
      check_all(t);
   endtask

   task automatic clear_inputs();
      id_ex_ctrl   = '0;
      id_ex_data   = '0;
      id_ex_valid  = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
      fwd_a_sel    = 2'd0;
      fwd_b_sel    = 2'd0;
      mem_fwd_data = '0;
      wb_fwd_data  = '0;
   endtask

   task automatic randomize_inputs();
      id_ex_ctrl.WB_reg_write    = 1'($urandom_range(0, 1));
      id_ex_ctrl.WB_mem_to_reg   = 1'($urandom_range(0, 1));
      id_ex_ctrl.M_branch        = 1'($urandom_range(0, 1));
      id_ex_ctrl.M_mem_read      = 1'($urandom_range(0, 1));
      id_ex_ctrl.M_mem_write     = 1'($urandom_range(0, 1));
      id_ex_ctrl.EX_ALU_Src      = 1'($urandom_range(0, 1));
      id_ex_ctrl.EX_ALU_Op       = alu_op_e'(2'($urandom_range(0, 3)));
      id_ex_data.pc_address      = $urandom;
      id_ex_data.reg_read_data1  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      id_ex_data.reg_read_data2  = ($urandom_range(0, 5) == 0) ? id_ex_data.reg_read_data1 : $urandom;
      id_ex_data.imm             = $urandom;
      id_ex_data.funct_inst_bits = 4'($urandom_range(0, 15));
      id_ex_data.rd              = 5'($urandom_range(0, 31));
      id_ex_valid                = ($urandom_range(0, 4) != 0);
      fwd_a_sel                  = 2'($urandom_range(0, 3));
      fwd_b_sel                  = 2'($urandom_range(0, 3));
      mem_fwd_data               = $urandom;
      wb_fwd_data                = $urandom;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      m   = reset_state();
      #12;
      check_all("reset");
      rst = 1'b0;

      // R-type ADD 5 + 7
      id_ex_ctrl.EX_ALU_Op       = ALU_OP_RTYPE;
      id_ex_ctrl.WB_reg_write    = 1'b1;
      id_ex_data.reg_read_data1  = 32'd5;
      id_ex_data.reg_read_data2  = 32'd7;
      id_ex_data.funct_inst_bits = 4'b0000;
      id_ex_data.rd              = 5'd3;
      id_ex_valid                = 1'b1;
      tick("radd");
      check("radd.alu_const", alu_result_q, 32'd12);
      check("radd.regwrite", ex_mem_ctrl_q.WB_reg_write, 1'b1);

      // Branch compare on equal operands
      clear_inputs();
      id_ex_ctrl.EX_ALU_Op      = ALU_OP_BRANCH;
      id_ex_ctrl.M_branch       = 1'b1;
      id_ex_data.reg_read_data1 = 32'h1234;
      id_ex_data.reg_read_data2 = 32'h1234;
      id_ex_data.pc_address     = 32'h100;
      id_ex_data.imm            = 32'd8;
      id_ex_valid               = 1'b1;
      tick("branch");
      check("branch.zero_const", zero_q, 1'b1);
      check("branch.target_const", branch_target_q, 32'h110);
      check("branch.mbranch", ex_mem_ctrl_q.M_branch, 1'b1);

      // Forwarded operand wraps to zero
      clear_inputs();
      id_ex_ctrl.EX_ALU_Op      = ALU_OP_RTYPE;
      fwd_a_sel                 = 2'b10;
      mem_fwd_data              = 32'hFFFF_FFFF;
      id_ex_data.reg_read_data2 = 32'd1;
      id_ex_valid               = 1'b1;
      tick("fwdwrap");
      check("fwdwrap.alu_const", alu_result_q, 32'd0);
      check("fwdwrap.zero_const", zero_q, 1'b1);

      // Store address via immediate, store data forwarded from WB
      clear_inputs();
      id_ex_ctrl.EX_ALU_Op      = ALU_OP_LOADSTORE;
      id_ex_ctrl.EX_ALU_Src     = 1'b1;
      id_ex_ctrl.M_mem_write    = 1'b1;
      id_ex_data.reg_read_data1 = 32'h1000;
      id_ex_data.imm            = 32'hFFFF_FFFC;
      fwd_b_sel                 = 2'b01;
      wb_fwd_data               = 32'hAB;
      id_ex_valid               = 1'b1;
      tick("store");
      check("store.alu_const", alu_result_q, 32'h0FFC);
      check("store.data_const", store_data_q, 32'hAB);
      check("store.memwrite", ex_mem_ctrl_q.M_mem_write, 1'b1);

      // Stall three cycles while inputs churn
      saved = m;
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         stall = 1'b1;
         flush = 1'b0;
         tick("stall");
         check("stall.alu_hold", alu_result_q, saved.alu);
         check("stall.store_hold", store_data_q, saved.store);
      end

      // Flush wins over a simultaneous stall
      randomize_inputs();
      id_ex_valid = 1'b1;
      stall = 1'b1;
      flush = 1'b1;
      tick("flush");
      check("flush.ctrl_zero", ex_mem_ctrl_q, 5'd0);
      check("flush.valid_zero", valid_q, 1'b0);

      // Unsupported R-type funct
      clear_inputs();
      id_ex_ctrl.EX_ALU_Op       = ALU_OP_RTYPE;
      id_ex_data.funct_inst_bits = 4'b0101;
      id_ex_data.reg_read_data1  = 32'h0000_1111;
      id_ex_data.reg_read_data2  = 32'h0000_2222;
      id_ex_valid                = 1'b1;
      tick("illegal");
      check("illegal.flag", illegal_q, 1'b1);
      check("illegal.alu_sum", alu_result_q, 32'h0000_3333);

      // Same funct on a bubble must not raise illegal
      id_ex_valid = 1'b0;
      tick("bubble");

      // Load something non-zero, then pulse reset between edges
      clear_inputs();
      randomize_inputs();
      id_ex_valid = 1'b1;
      id_ex_data.rd = 5'd17;
      tick("prereset");
      #2;
      rst = 1'b1;
      #1;
      m = reset_state();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      #2;
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
